pmci_spi_csr_bridge: RTL and testbench

- Host-facing CSR slave for the PMCI SPI window: SPI_CSR at PMCI base + 0x400, SPI_AR at +0x404, SPI_RD_DR at +0x408, SPI_WR_DR at +0x40C.
- Converts host register accesses into single Avalon-MM read/write transactions toward the PMCI SPI master (board-management flash/MAX10 path).
- Sits downstream of the PMCI CSR decode; its upstream is the host CSR path that drives those offsets.

---
 rtl/pmci_spi_bridge_pkg.sv | 27 ++
 rtl/pmci_spi_av_master.sv | 136 +++++++++++++
 rtl/pmci_spi_csr_bridge.sv | 147 ++++++++++++++
 tb/tb_pmci_spi_csr_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmci_spi_bridge_pkg.sv
// pmci_spi_bridge_pkg
//   Shared definitions for the PMCI SPI CSR bridge: register offsets inside
//   the PMCI window, SPI_CSR bit positions and the Avalon-MM master FSM states.
package pmci_spi_bridge_pkg;

   // Register byte offsets within the PMCI window
   localparam logic [15:0] SPI_CSR_OFS   = 16'h0400;
   localparam logic [15:0] SPI_AR_OFS    = 16'h0404;
   localparam logic [15:0] SPI_RD_DR_OFS = 16'h0408;
   localparam logic [15:0] SPI_WR_DR_OFS = 16'h040C;

   // SPI_CSR bit positions
   localparam int CSR_WR_REQ = 0;
   localparam int CSR_RD_REQ = 1;
   localparam int CSR_BUSY   = 2;
   localparam int CSR_ERR    = 3;
   localparam int CSR_DONE   = 4;

   // Avalon-MM master states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR      = 2'd1,
      ST_RD_CMD  = 2'd2,
      ST_RD_WAIT = 2'd3
   } spi_state_e;

endpackage

// File: rtl/pmci_spi_av_master.sv
// pmci_spi_av_master
//   Runs one Avalon-MM read or write toward the PMCI SPI master per start
//   request, with a per-transaction cycle limit.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_start_wr/i_start_rd one-cycle start requests (write has priority)
//   i_addr, i_wdata       address / write data captured at start
//   o_spi_*, i_spi_*      Avalon-MM master interface
//   o_busy                registered, high whenever the FSM is not idle
//   o_wr_done, o_rd_done  completion pulses (combinational, this cycle)
//   o_timeout             abort pulse: limit reached without completion
module pmci_spi_av_master
   import pmci_spi_bridge_pkg::*;
#(
   parameter int SPI_AW  = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start_wr,
   input  logic              i_start_rd,
   input  logic [SPI_AW-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic [SPI_AW-1:0] o_spi_address,
   output logic              o_spi_write,
   output logic              o_spi_read,
   output logic [31:0]       o_spi_writedata,
   input  logic              i_spi_waitrequest,
   input  logic              i_spi_readdatavalid,
   output logic              o_busy,
   output logic              o_wr_done,
   output logic              o_rd_done,
   output logic              o_timeout
);

   localparam int              CW           = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0]   LP_CNT_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   LP_CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

   spi_state_e        r_state;
   logic [CW-1:0]     r_cnt;
   logic [SPI_AW-1:0] r_spi_address;
   logic              r_spi_write;
   logic              r_spi_read;
   logic [31:0]       r_spi_writedata;
   logic              r_busy;

   logic w_wr_done;
   logic w_rd_done;
   logic w_timeout;

   // Completion beats a timeout landing on the same cycle
   assign w_wr_done = (r_state == ST_WR) && !i_spi_waitrequest;
   assign w_rd_done = (r_state == ST_RD_WAIT) && i_spi_readdatavalid;
   assign w_timeout = (r_state != ST_IDLE) && (r_cnt == LP_CNT_LAST)
                      && !w_wr_done && !w_rd_done;

   // Transaction FSM, timeout counter and registered Avalon-MM drive
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         r_spi_address   <= '0;
         r_spi_write     <= 1'b0;
         r_spi_read      <= 1'b0;
         r_spi_writedata <= 32'h0;
         r_busy          <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start_wr) begin
                  r_state         <= ST_WR;
                  r_cnt           <= '0;
                  r_spi_address   <= i_addr;
                  r_spi_writedata <= i_wdata;
                  r_spi_write     <= 1'b1;
                  r_busy          <= 1'b1;
               end else if (i_start_rd) begin
                  r_state       <= ST_RD_CMD;
                  r_cnt         <= '0;
                  r_spi_address <= i_addr;
                  r_spi_read    <= 1'b1;
                  r_busy        <= 1'b1;
               end
            end
            ST_WR: begin
               if (w_wr_done || w_timeout) begin
                  r_state     <= ST_IDLE;
                  r_spi_write <= 1'b0;
                  r_busy      <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + LP_CNT_ONE;
               end
            end
            ST_RD_CMD: begin
               // The command is accepted on the first non-stalled cycle
               if (w_timeout) begin
                  r_state    <= ST_IDLE;
                  r_spi_read <= 1'b0;
                  r_busy     <= 1'b0;
               end else if (!i_spi_waitrequest) begin
                  r_state    <= ST_RD_WAIT;
                  r_spi_read <= 1'b0;
                  r_cnt      <= r_cnt + LP_CNT_ONE;
               end else begin
                  r_cnt <= r_cnt + LP_CNT_ONE;
               end
            end
            ST_RD_WAIT: begin
               if (w_rd_done || w_timeout) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + LP_CNT_ONE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_spi_write <= 1'b0;
               r_spi_read  <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_spi_address   = r_spi_address;
   assign o_spi_write     = r_spi_write;
   assign o_spi_read      = r_spi_read;
   assign o_spi_writedata = r_spi_writedata;
   assign o_busy          = r_busy;
   assign o_wr_done       = w_wr_done;
   assign o_rd_done       = w_rd_done;
   assign o_timeout       = w_timeout;

endmodule

// File: rtl/pmci_spi_csr_bridge.sv
// pmci_spi_csr_bridge
//   Host CSR slave for the PMCI SPI window (SPI_CSR, SPI_AR, SPI_RD_DR,
//   SPI_WR_DR). Host register writes launch single Avalon-MM transactions
//   through pmci_spi_av_master; this level holds the registers and read mux.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   csr_addr/write/read/wdata         host CSR access (byte offset in window)
//   csr_rdata, csr_rvalid             read data, valid one cycle after read
//   spi_*                             Avalon-MM master toward the SPI master
//   busy                              transaction in flight
module pmci_spi_csr_bridge
   import pmci_spi_bridge_pkg::*;
#(
   parameter logic [15:0] BASE    = 16'h0400,
   parameter int          SPI_AW  = 16,
   parameter int          TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       csr_addr,
   input  logic              csr_write,
   input  logic              csr_read,
   input  logic [31:0]       csr_wdata,
   output logic [31:0]       csr_rdata,
   output logic              csr_rvalid,
   output logic [SPI_AW-1:0] spi_address,
   output logic              spi_write,
   output logic              spi_read,
   output logic [31:0]       spi_writedata,
   input  logic              spi_waitrequest,
   input  logic [31:0]       spi_readdata,
   input  logic              spi_readdatavalid,
   output logic              busy
);

   // Register addresses relative to the configured base
   localparam logic [15:0] LP_CSR_A   = BASE;
   localparam logic [15:0] LP_AR_A    = BASE + (SPI_AR_OFS - SPI_CSR_OFS);
   localparam logic [15:0] LP_RD_DR_A = BASE + (SPI_RD_DR_OFS - SPI_CSR_OFS);
   localparam logic [15:0] LP_WR_DR_A = BASE + (SPI_WR_DR_OFS - SPI_CSR_OFS);

   logic [SPI_AW-1:0] r_ar;
   logic [31:0]       r_wr_dr;
   logic [31:0]       r_rd_dr;
   logic              r_err;
   logic              r_done;
   logic [31:0]       r_rdata;
   logic              r_rvalid;

   logic        w_busy;
   logic        w_wr_done;
   logic        w_rd_done;
   logic        w_timeout;
   logic        w_csr_wr;
   logic        w_start_wr;
   logic        w_start_rd;
   logic        w_req_drop;
   logic [31:0] w_rd_mux;

   // A request with both bits set launches only the write
   assign w_csr_wr   = csr_write && (csr_addr == LP_CSR_A);
   assign w_start_wr = w_csr_wr && !w_busy && csr_wdata[CSR_WR_REQ];
   assign w_start_rd = w_csr_wr && !w_busy && csr_wdata[CSR_RD_REQ]
                       && !csr_wdata[CSR_WR_REQ];
   assign w_req_drop = w_csr_wr && w_busy
                       && (csr_wdata[CSR_WR_REQ] || csr_wdata[CSR_RD_REQ]);

   pmci_spi_av_master #(
      .SPI_AW  (SPI_AW),
      .TIMEOUT (TIMEOUT)
   ) u_av_master (
      .clk                 (clk),
      .reset               (reset),
      .i_start_wr          (w_start_wr),
      .i_start_rd          (w_start_rd),
      .i_addr              (r_ar),
      .i_wdata             (r_wr_dr),
      .o_spi_address       (spi_address),
      .o_spi_write         (spi_write),
      .o_spi_read          (spi_read),
      .o_spi_writedata     (spi_writedata),
      .i_spi_waitrequest   (spi_waitrequest),
      .i_spi_readdatavalid (spi_readdatavalid),
      .o_busy              (w_busy),
      .o_wr_done           (w_wr_done),
      .o_rd_done           (w_rd_done),
      .o_timeout           (w_timeout)
   );

   // Host read mux; unmapped offsets read as zero
   always_comb begin
      w_rd_mux = 32'h0;
      case (csr_addr)
         LP_CSR_A: begin
            w_rd_mux[CSR_BUSY] = w_busy;
            w_rd_mux[CSR_ERR]  = r_err;
            w_rd_mux[CSR_DONE] = r_done;
         end
         LP_AR_A:    w_rd_mux[SPI_AW-1:0] = r_ar;
         LP_RD_DR_A: w_rd_mux = r_rd_dr;
         LP_WR_DR_A: w_rd_mux = r_wr_dr;
         default:    w_rd_mux = 32'h0;
      endcase
   end

   // Register file, sticky status bits and registered read port
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ar     <= '0;
         r_wr_dr  <= 32'h0;
         r_rd_dr  <= 32'h0;
         r_err    <= 1'b0;
         r_done   <= 1'b0;
         r_rdata  <= 32'h0;
         r_rvalid <= 1'b0;
      end else begin
         // Address and write data are frozen while a transaction runs
         if (csr_write && !w_busy && (csr_addr == LP_AR_A)) begin
            r_ar <= csr_wdata[SPI_AW-1:0];
         end
         if (csr_write && !w_busy && (csr_addr == LP_WR_DR_A)) begin
            r_wr_dr <= csr_wdata;
         end
         if (w_rd_done) begin
            r_rd_dr <= spi_readdata;
         end
         // Hardware set wins over a host write-1-to-clear
         if (w_timeout || w_req_drop) begin
            r_err <= 1'b1;
         end else if (w_csr_wr && csr_wdata[CSR_ERR]) begin
            r_err <= 1'b0;
         end
         if (w_wr_done || w_rd_done) begin
            r_done <= 1'b1;
         end else if (w_start_wr || w_start_rd || (w_csr_wr && csr_wdata[CSR_DONE])) begin
            r_done <= 1'b0;
         end
         r_rvalid <= csr_read;
         r_rdata  <= csr_read ? w_rd_mux : 32'h0;
      end
   end

   assign csr_rdata  = r_rdata;
   assign csr_rvalid = r_rvalid;
   assign busy       = w_busy;

endmodule

// File: tb/tb_pmci_spi_csr_bridge.sv
// tb_pmci_spi_csr_bridge
//   Self-checking bench: directed scenarios plus randomized transactions,
//   compared against a register-level reference model of the SPI window.
module tb_pmci_spi_csr_bridge;
   import pmci_spi_bridge_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] csr_addr;
   logic        csr_write;
   logic        csr_read;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_rvalid;
   logic [15:0] spi_address;
   logic        spi_write;
   logic        spi_read;
   logic [31:0] spi_writedata;
   logic        spi_waitrequest;
   logic [31:0] spi_readdata;
   logic        spi_readdatavalid;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model of the host-visible registers
   logic [31:0] m_ar, m_wr_dr, m_rd_dr;
   logic        m_err, m_done;

   pmci_spi_csr_bridge #(
      .BASE    (16'h0400),
      .SPI_AW  (16),
      .TIMEOUT (TO)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .csr_addr          (csr_addr),
      .csr_write         (csr_write),
      .csr_read          (csr_read),
      .csr_wdata         (csr_wdata),
      .csr_rdata         (csr_rdata),
      .csr_rvalid        (csr_rvalid),
      .spi_address       (spi_address),
      .spi_write         (spi_write),
      .spi_read          (spi_read),
      .spi_writedata     (spi_writedata),
      .spi_waitrequest   (spi_waitrequest),
      .spi_readdata      (spi_readdata),
      .spi_readdatavalid (spi_readdatavalid),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] m_csr();
      return {27'h0, m_done, m_err, 3'b000};
   endfunction

   // Model effect of a host write issued while idle
   task automatic m_wr(input logic [15:0] a, input logic [31:0] d);
      case (a)
         SPI_CSR_OFS: begin
            if (d[3]) m_err = 1'b0;
            if (d[4] || d[0] || d[1]) m_done = 1'b0;
         end
         SPI_AR_OFS:    m_ar    = {16'h0, d[15:0]};
         SPI_WR_DR_OFS: m_wr_dr = d;
         default: ;
      endcase
   endtask

   task automatic csr_wr(input logic [15:0] a, input logic [31:0] d);
      csr_addr  = a;
      csr_wdata = d;
      csr_write = 1'b1;
      @(negedge clk);
      csr_write = 1'b0;
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
      csr_wr(a, d);
      m_wr(a, d);
   endtask

   task automatic csr_rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
      csr_addr = a;
      csr_read = 1'b1;
      @(negedge clk);
      csr_read = 1'b0;
      chk({tag, "_rvalid"}, {31'h0, csr_rvalid}, 32'h1);
      chk(tag, csr_rdata, exp);
   endtask

   // Launch a request and act as the SPI slave. Expected timing comes from
   // counting cycles: a write needs n_wait+1 cycles, a read needs
   // n_wait+1 command cycles plus rd_lat+1 wait cycles; anything longer than
   // TO cycles is cut at TO with ERR.
   task automatic run_xact(input string tag, input logic [31:0] csr_val, input int n_wait,
                           input int rd_lat, input logic [31:0] rdata, input bit inj);
      bit          is_wr, tout, acc, rdv_done;
      int          need, exp_busy, exp_cmd;
      int          busy_c, wr_c, rd_c, bad, cd;
      logic [15:0] exp_addr;
      logic [31:0] exp_data;
      is_wr    = csr_val[0];
      exp_addr = m_ar[15:0];
      exp_data = m_wr_dr;
      need     = is_wr ? n_wait + 1 : n_wait + rd_lat + 2;
      tout     = need > TO;
      exp_busy = tout ? TO : need;
      exp_cmd  = (n_wait + 1 > TO) ? TO : n_wait + 1;
      busy_c = 0; wr_c = 0; rd_c = 0; bad = 0; cd = 0; acc = 1'b0; rdv_done = 1'b0;
      wr_reg(SPI_CSR_OFS, csr_val);
      for (int i = 0; i < 200; i++) begin
         spi_waitrequest   = 1'b0;
         spi_readdatavalid = 1'b0;
         spi_readdata      = $urandom;
         csr_write         = 1'b0;
         if (!busy) break;
         busy_c++;
         if (inj && i == 1) begin
            csr_write = 1'b1; csr_addr = SPI_CSR_OFS; csr_wdata = 32'h2;
         end
         if (inj && i == 2) begin
            csr_write = 1'b1; csr_addr = SPI_WR_DR_OFS; csr_wdata = 32'h1111;
         end
         if (spi_write) begin
            wr_c++;
            if (spi_address !== exp_addr || spi_writedata !== exp_data) bad++;
            spi_waitrequest = (wr_c <= n_wait);
         end
         if (spi_read) begin
            rd_c++;
            if (spi_address !== exp_addr) bad++;
            spi_waitrequest = (rd_c <= n_wait);
            if (rd_c > n_wait) begin
               acc = 1'b1;
               cd  = rd_lat;
            end
         end else if (acc && !rdv_done) begin
            if (cd == 0) begin
               spi_readdatavalid = 1'b1;
               spi_readdata      = rdata;
               rdv_done          = 1'b1;
            end else begin
               cd--;
            end
         end
         @(negedge clk);
      end
      spi_waitrequest   = 1'b0;
      spi_readdatavalid = 1'b0;
      csr_write         = 1'b0;
      if (tout) begin
         m_err = 1'b1;
      end else begin
         m_done = 1'b1;
         if (!is_wr) m_rd_dr = rdata;
      end
      if (inj) m_err = 1'b1;
      chk({tag, "_busy_cycles"}, busy_c, exp_busy);
      chk({tag, "_write_cycles"}, wr_c, is_wr ? exp_cmd : 0);
      chk({tag, "_read_cycles"}, rd_c, is_wr ? 0 : exp_cmd);
      chk({tag, "_addr_data_errs"}, bad, 0);
      csr_rd({tag, "_csr"}, SPI_CSR_OFS, m_csr());
   endtask

   initial begin
      reset = 1'b1; csr_addr = 16'h0; csr_write = 1'b0; csr_read = 1'b0; csr_wdata = 32'h0;
      spi_waitrequest = 1'b0; spi_readdata = 32'h0; spi_readdatavalid = 1'b0;
      m_ar = 32'h0; m_wr_dr = 32'h0; m_rd_dr = 32'h0; m_err = 1'b0; m_done = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      chk("rst_ctrl", {28'h0, busy, spi_write, spi_read, csr_rvalid}, 32'h0);
      chk("rst_addr", {16'h0, spi_address}, 32'h0);
      chk("rst_wdata", spi_writedata, 32'h0);
      chk("rst_rdata", csr_rdata, 32'h0);
      csr_rd("rst_csr", SPI_CSR_OFS, 32'h0);
      csr_rd("unmapped_hi", 16'h0410, 32'h0);
      csr_rd("unmapped_lo", 16'h0000, 32'h0);

      // Basic write with three stall cycles
      wr_reg(SPI_AR_OFS, 32'h0000_0123);
      wr_reg(SPI_WR_DR_OFS, 32'hDEAD_BEEF);
      run_xact("basic_wr", 32'h1, 3, 0, 32'h0, 1'b0);
      chk("basic_wr_csr_const", m_csr(), 32'h10);

      // Basic read, data five cycles after the command is accepted
      wr_reg(SPI_AR_OFS, 32'h0000_0040);
      run_xact("basic_rd", 32'h2, 0, 4, 32'hA5A5_5A5A, 1'b0);
      csr_rd("basic_rd_dr", SPI_RD_DR_OFS, 32'hA5A5_5A5A);

      // Timeout: no read data ever
      run_xact("tmo_rd", 32'h2, 0, 1000, 32'h0, 1'b0);
      csr_rd("tmo_rd_dr", SPI_RD_DR_OFS, 32'hA5A5_5A5A);
      wr_reg(SPI_CSR_OFS, 32'h8);
      csr_rd("tmo_err_clr", SPI_CSR_OFS, 32'h0);

      // Completion on the last allowed cycle versus one cycle too late
      run_xact("edge_wr_ok", 32'h1, TO - 1, 0, 32'h0, 1'b0);
      run_xact("edge_wr_tmo", 32'h1, TO, 0, 32'h0, 1'b0);
      wr_reg(SPI_CSR_OFS, 32'h18);
      run_xact("edge_rd_ok", 32'h2, 2, TO - 4, 32'h1357_9BDF, 1'b0);
      run_xact("edge_rd_tmo", 32'h2, 2, TO - 3, 32'h2468_ACE0, 1'b0);
      csr_rd("edge_rd_dr", SPI_RD_DR_OFS, m_rd_dr);

      // Requests and data writes while busy are dropped and flag ERR
      wr_reg(SPI_CSR_OFS, 32'h18);
      wr_reg(SPI_WR_DR_OFS, 32'hCAFE_0001);
      run_xact("busy_req", 32'h1, 6, 0, 32'h0, 1'b1);
      csr_rd("busy_wr_dr", SPI_WR_DR_OFS, 32'hCAFE_0001);

      // Both request bits: write only
      wr_reg(SPI_CSR_OFS, 32'h18);
      run_xact("both_req", 32'h3, 1, 0, 32'h0, 1'b0);

      // AR upper bits read zero
      wr_reg(SPI_AR_OFS, 32'hFFFF_1234);
      csr_rd("ar_upper", SPI_AR_OFS, 32'h0000_1234);

      // Randomized transactions
      for (int k = 0; k < 25; k++) begin
         logic [31:0] v;
         v = {27'h0, 1'($urandom), 1'($urandom), 3'b000};
         wr_reg(SPI_CSR_OFS, v);
         wr_reg(SPI_AR_OFS, $urandom);
         wr_reg(SPI_WR_DR_OFS, $urandom);
         csr_rd("rnd_ar", SPI_AR_OFS, m_ar);
         v = $urandom;
         v[2:0] = 3'($urandom_range(1, 3));
         run_xact("rnd", v, $urandom_range(0, 9), $urandom_range(0, 9), $urandom, 1'b0);
         csr_rd("rnd_rd_dr", SPI_RD_DR_OFS, m_rd_dr);
         csr_rd("rnd_wr_dr", SPI_WR_DR_OFS, m_wr_dr);
      end

      // Reset while waiting for read data, then a stale readdatavalid
      wr_reg(SPI_AR_OFS, 32'h0000_0055);
      csr_wr(SPI_CSR_OFS, 32'h2);
      chk("rstrd_cmd", {31'h0, spi_read}, 32'h1);
      spi_waitrequest = 1'b0;
      @(negedge clk);
      chk("rstrd_wait", {30'h0, busy, spi_read}, 32'h2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      spi_readdatavalid = 1'b1;
      spi_readdata      = 32'hFFFF_FFFF;
      @(negedge clk);
      spi_readdatavalid = 1'b0;
      m_ar = 32'h0; m_wr_dr = 32'h0; m_rd_dr = 32'h0; m_err = 1'b0; m_done = 1'b0;
      chk("rstrd_ctrl", {28'h0, busy, spi_write, spi_read, csr_rvalid}, 32'h0);
      chk("rstrd_addr", {16'h0, spi_address}, 32'h0);
      csr_rd("rstrd_rd_dr", SPI_RD_DR_OFS, m_rd_dr);
      csr_rd("rstrd_csr", SPI_CSR_OFS, m_csr());
      csr_rd("rstrd_ar", SPI_AR_OFS, m_ar);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
